uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200); legal range 8..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rxd  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 rd_en  input  1  pop strobe from CPU I/O decode, one pop per cycle high.
REQ-007 clear_err  input  1  clears framing_err and overrun.
REQ-008 rd_data  output  8  FIFO head byte, first-word-fall-through; 0x00 when empty.
REQ-009 rx_valid  output  1  FIFO not empty.
REQ-010 rx_full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-011 framing_err  output  1  sticky: a frame had stop bit 0.
REQ-012 overrun  output  1  sticky: a good byte was dropped because the FIFO was full.

Function
REQ-013 rxd SHALL pass a 2-flop synchronizer; all logic uses synchronized rxd_s, reset value 1.
REQ-014 FSM states IDLE, START, DATA, STOP, BREAK; one bit counter (0..CLKS_PER_BIT-1) and a 3-bit index.
REQ-015 IDLE -> START when rxd_s is 0; bit counter cleared.
REQ-016 START: after CLKS_PER_BIT/2 cycles (floor), sample rxd_s: 0 -> DATA; 1 -> IDLE (glitch, nothing recorded).
REQ-017 DATA: sample rxd_s every CLKS_PER_BIT cycles into the shift register, LSB first; the 8th sample moves the FSM to STOP.
REQ-018 STOP: after CLKS_PER_BIT cycles, sample rxd_s: 1 -> push byte, go to IDLE; 0 -> set framing_err, discard byte, go to BREAK.
REQ-019 BREAK: stay until rxd_s is 1, then go to IDLE; a continuous low line produces exactly one framing error.
REQ-020 Push happens on the stop-sample edge; rx_valid rises the following cycle. rxd edge to rx_valid is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles.
REQ-021 Push while full with no pop in the same cycle: drop the byte, set overrun, FIFO unchanged.
REQ-022 Push and pop in the same cycle while full: both occur, no overrun.
REQ-023 Push and pop in the same cycle while empty: push only, because the pop is ignored.
REQ-024 rd_en while empty is ignored; pointers do not move.
REQ-025 FIFO pointers wrap modulo FIFO_DEPTH; the count ranges 0..FIFO_DEPTH.
REQ-026 clear_err in the same cycle as a new error event: the new error wins, and the flag reads 1.
REQ-027 The receiver SHALL never apply back-pressure to the line; reception continues while the FIFO is full.

Reset
REQ-028 Reset asserted: FSM to IDLE, counters and shift register 0, synchronizer flops 1, FIFO empty.
REQ-029 Reset values: rd_data=0x00, rx_valid=0, rx_full=0, framing_err=0, overrun=0.
REQ-030 Reset mid-frame: the partial byte is lost; after release the block waits for a fresh falling edge, with no spurious push or error.

Structure
REQ-031 Shared package uart_pkg holds the rx_state_t enum and default constants (CLKS_PER_BIT_115200=434, RX_FIFO_DEPTH=4).
REQ-032 The FIFO SHALL be a sub-module, sync_fifo (parameterised WIDTH and DEPTH, FWFT, full/empty outputs); the FSM and synchronizer live in uart_rx.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-033 Send frame 0x6C ('l'), no pop -> rx_valid rises 2+8+144+1=155 cycles after the start edge; rd_data=0x6C; one rd_en -> rx_valid=0.
REQ-034 rxd low for 4 cycles, then high -> FSM returns to IDLE; rx_valid=0, framing_err=0.
REQ-035 Send 0x55 with stop bit 0, hold low 40 cycles, then high -> framing_err=1, rx_valid=0; pulse clear_err -> framing_err=0; a following 0x0D is received correctly.
REQ-036 Send 0x31..0x35 back-to-back, no pops -> rx_full=1, overrun=1; popping returns 0x31, 0x32, 0x33, 0x34, then rx_valid=0.
REQ-037 FIFO full, rd_en asserted on the push cycle of 0x41 -> overrun stays 0; pops return the remaining 3 old bytes, then 0x41.
REQ-038 Assert reset during DATA bit 4 of 0xA5; release; send 0x3C -> only 0x3C is received, framing_err=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int CLKS_PER_BIT_115200 = 434;
  localparam int RX_FIFO_DEPTH       = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; a write while full is accepted
// only when a read frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_wr && !do_rd) begin
      count_d = count_q + 1'b1;
    end else if (!do_wr && do_rd) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; empty gates the visible head.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: line synchronizer, mid-bit sampling FSM and a small
// receive FIFO with sticky framing/overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int FIFO_DEPTH   = RX_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       rd_en,
  input  logic       clear_err,
  output logic [7:0] rd_data,
  output logic       rx_valid,
  output logic       rx_full,
  output logic       framing_err,
  output logic       overrun
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  rx_state_t   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        sync1_q, sync1_d;
  logic        rxd_s_q, rxd_s_d;
  logic        fe_q, fe_d;
  logic        ov_q, ov_d;
  logic        push, set_fe, set_ov;
  logic        fifo_full, fifo_empty;

  always_comb begin
    sync1_d  = rxd;
    rxd_s_d  = sync1_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    push     = 1'b0;
    set_fe   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rxd_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // Re-check the start bit at its middle to reject line glitches.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxd_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            set_fe  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      BREAK: begin
        // Wait out a held-low line so it reports only one framing error.
        if (rxd_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new error event outranks a simultaneous clear.
  assign set_ov = push && fifo_full && !rd_en;
  always_comb begin
    fe_d = set_fe || (fe_q && !clear_err);
    ov_d = set_ov || (ov_q && !clear_err);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      rxd_s_q <= rxd_s_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (shift_q),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign rx_valid    = !fifo_empty;
  assign rx_full     = fifo_full;
  assign framing_err = fe_q;
  assign overrun     = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a frame-level model predicts when each byte lands in the
// receive queue and the outputs are compared against it every cycle.
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int LAT   = 2 + CPB/2 + 9*CPB + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       rd_en = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] rd_data;
  logic       rx_valid, rx_full, framing_err, overrun;

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .rxd         (rxd),
    .rd_en       (rd_en),
    .clear_err   (clear_err),
    .rd_data     (rd_data),
    .rx_valid    (rx_valid),
    .rx_full     (rx_full),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         t;
    logic [7:0] b;
    bit         bad;
  } ev_t;

  logic [7:0] mq[$];
  ev_t        evq[$];
  bit         m_fe = 1'b0;
  bit         m_ov = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Queue-level model: each frame resolves at start + LAT edges.
  initial forever begin
    ev_t        ev;
    bit         pop, push, fe_ev, ov_ev;
    logic [7:0] b;
    @(posedge clk);
    cyc++;
    if (reset) begin
      mq.delete();
      evq.delete();
      m_fe = 1'b0;
      m_ov = 1'b0;
    end else begin
      push  = 1'b0;
      fe_ev = 1'b0;
      ov_ev = 1'b0;
      b     = 8'h00;
      if (evq.size() > 0 && evq[0].t == cyc) begin
        ev = evq.pop_front();
        if (ev.bad) fe_ev = 1'b1;
        else begin
          push = 1'b1;
          b    = ev.b;
        end
      end
      pop = rd_en && (mq.size() > 0);
      if (push && mq.size() == DEPTH && !pop) ov_ev = 1'b1;
      if (pop) void'(mq.pop_front());
      if (push && !ov_ev) mq.push_back(b);
      m_fe = fe_ev || (m_fe && !clear_err);
      m_ov = ov_ev || (m_ov && !clear_err);
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("rx_valid", rx_valid, mq.size() > 0);
      chk("rd_data", rd_data, (mq.size() > 0) ? mq[0] : 8'h00);
      chk("rx_full", rx_full, mq.size() == DEPTH);
      chk("framing_err", framing_err, m_fe);
      chk("overrun", overrun, m_ov);
    end
  end

  // Called at posedge+1; leaves the line high after the stop bit (plus any extra low hold).
  task automatic send(input logic [7:0] b, input bit stop_ok, input int hold_low);
    evq.push_back('{cyc + LAT, b, !stop_ok});
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop_ok;
    tick(CPB + (stop_ok ? 0 : hold_low));
    rxd = 1'b1;
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] exp);
    chk(nm, rd_data, exp);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
  endtask

  bit rand_done = 1'b0;

  initial begin
    int n;
    tick(3);
    chk("reset rd_data", rd_data, 8'h00);
    chk("reset rx_valid", rx_valid, 1'b0);
    chk("reset rx_full", rx_full, 1'b0);
    chk("reset framing_err", framing_err, 1'b0);
    chk("reset overrun", overrun, 1'b0);
    reset = 1'b0;
    tick(5);

    // Single frame latency and first-word-fall-through.
    n = 0;
    fork
      send(8'h6C, 1'b1, 0);
      begin
        do begin
          tick(1);
          n++;
        end while (!rx_valid && n < 300);
      end
    join
    chk("latency", n, 155);
    chk("byte 6C", rd_data, 8'h6C);
    pop_chk("pop 6C", 8'h6C);
    chk("empty after pop", rx_valid, 1'b0);

    // Short glitch must not start a frame.
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(30);
    chk("glitch rx_valid", rx_valid, 1'b0);
    chk("glitch framing_err", framing_err, 1'b0);

    // Bad stop bit with long low hold: one error only.
    fork
      send(8'h55, 1'b0, 40);
      begin
        tick(165);
        chk("break framing_err", framing_err, 1'b1);
        chk("break rx_valid", rx_valid, 1'b0);
        tick(5);
        pulse_clear();
      end
    join
    tick(CPB);
    chk("single framing error", framing_err, 1'b0);
    send(8'h0D, 1'b1, 0);
    tick(4);
    pop_chk("after break 0D", 8'h0D);

    // Overrun: five frames into a four-entry queue.
    for (int i = 0; i < 5; i++) send(8'h31 + 8'(i), 1'b1, 0);
    tick(20);
    chk("ovr rx_full", rx_full, 1'b1);
    chk("ovr overrun", overrun, 1'b1);
    pop_chk("ovr pop 31", 8'h31);
    pop_chk("ovr pop 32", 8'h32);
    pop_chk("ovr pop 33", 8'h33);
    pop_chk("ovr pop 34", 8'h34);
    chk("ovr drained", rx_valid, 1'b0);
    pulse_clear();
    chk("ovr cleared", overrun, 1'b0);

    // Push and pop together while full.
    for (int i = 0; i < 4; i++) send(8'h21 + 8'(i), 1'b1, 0);
    tick(4);
    chk("full before 41", rx_full, 1'b1);
    fork
      send(8'h41, 1'b1, 0);
      begin
        tick(LAT - 1);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
      end
    join
    chk("simul no overrun", overrun, 1'b0);
    pop_chk("simul pop 22", 8'h22);
    pop_chk("simul pop 23", 8'h23);
    pop_chk("simul pop 24", 8'h24);
    pop_chk("simul pop 41", 8'h41);
    chk("simul drained", rx_valid, 1'b0);

    // Reset in the middle of data bit 4, with a byte already queued.
    send(8'h77, 1'b1, 0);
    tick(4);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = (8'hA5 >> i) & 1;
      tick(CPB);
    end
    rxd = 1'b0;
    tick(CPB/2);
    reset = 1'b1;
    tick(3);
    chk("midreset rx_valid", rx_valid, 1'b0);
    chk("midreset rd_data", rd_data, 8'h00);
    rxd = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(10);
    chk("post reset idle", rx_valid, 1'b0);
    send(8'h3C, 1'b1, 0);
    tick(4);
    chk("post reset fe", framing_err, 1'b0);
    pop_chk("post reset 3C", 8'h3C);
    chk("post reset drained", rx_valid, 1'b0);

    // Randomized traffic with random pops and clears.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          bit bad;
          tick($urandom_range(0, 20));
          if ($urandom_range(0, 9) == 0) begin
            rxd = 1'b0;
            tick($urandom_range(1, 4));
            rxd = 1'b1;
            tick(CPB);
          end
          bad = ($urandom_range(0, 7) == 0);
          send(8'($urandom), !bad, bad ? $urandom_range(0, 30) : 0);
          if (bad) tick(2*CPB);
        end
        tick(4);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          rd_en     = ($urandom_range(0, 3) == 0);
          clear_err = ($urandom_range(0, 63) == 0);
          tick(1);
        end
        rd_en     = 1'b0;
        clear_err = 1'b0;
      end
    join
    n = 0;
    while (rx_valid && n < 20) begin
      rd_en = 1'b1;
      tick(1);
      n++;
    end
    rd_en = 1'b0;
    tick(1);
    chk("random drained", rx_valid, 1'b0);
    pulse_clear();
    chk("random fe cleared", framing_err, 1'b0);
    chk("random ov cleared", overrun, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #700000;
    checks++;
    errors++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
